stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-input, W-bit streaming multiplexer with valid/ready handshake and
//  built-in arbitration. Successor to the fixed 2:1 16-bit bit-sliced select muxes:
//  the select is generated internally (round-robin or fixed priority), the output is
//  registered, and multi-beat packets hold the grant until their last beat.
//  Sits between producer channels and a shared consumer (bus port, ALU operand path).
// PARAMETERS
//  NUM_IN   4   number of input channels (>=1)
//  WIDTH    16  data width per channel, bits (>=1)
//  ARB_MODE 0   0 = round-robin (ARB_RR), 1 = fixed priority, channel 0 highest (ARB_FIXED)
//  SEL_W    derived: max(1, $clog2(NUM_IN)); localparam, not overridable
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous reset, active low
//  in_valid   in   NUM_IN       per-channel beat valid
//  in_data    in   NUM_IN*WIDTH channel i at [i*WIDTH +: WIDTH]
//  in_last    in   NUM_IN       per-channel end-of-packet flag (1 = single/last beat)
//  in_ready   out  NUM_IN       per-channel accept; transfer when in_valid[i]&in_ready[i]
//  out_valid  out  1            registered output beat valid
//  out_data   out  WIDTH        registered output data
//  out_last   out  1            registered copy of accepted in_last
//  out_sel    out  SEL_W        index of channel that supplied the current out beat
//  out_ready  in   1            consumer accept; transfer when out_valid&out_ready
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_last=0, out_sel=0,
//    rr pointer=0, state=IDLE. While rst_n=0, in_ready=0 combinationally.
//  - load = !out_valid | out_ready. in_ready[i] = load & grant[i] (one-hot or zero).
//    in_ready may depend on in_valid; out_valid never depends on out_ready.
//  - Latency 1: beat accepted at edge t is on out_* from t+1. Full throughput
//    (1 beat/cycle) while out_ready=1.
//  - Backpressure: out_valid=1 & out_ready=0 -> out_* held stable, all in_ready=0.
//  - State IDLE: grant = arbiter choice among in_valid.
//      RR: first requesting index at or after pointer, wrapping NUM_IN-1 -> 0.
//      FIXED: lowest requesting index.
//    Accept with in_last=1 -> stay IDLE; accept with in_last=0 -> LOCKED on that index.
//  - State LOCKED(g): grant = g only (if in_valid[g]); others stall even if valid.
//    Accept from g with in_last=1 -> IDLE. No timeout; bubbles on g allowed.
//  - RR pointer updates only on a last-beat accept: pointer = (g+1) mod NUM_IN.
//    Non-last beats and idle cycles leave pointer unchanged. FIXED ignores pointer.
//  - No valid inputs while load: out_valid falls to 0 after current beat drains;
//    out_data/out_sel keep last values.
//  - Simultaneous drain and load in one cycle is a normal transfer (no bubble).
//  - Reset mid-packet: LOCKED abandoned, held beat dropped, all state to reset values.
//  - NUM_IN=1: arbiter degenerates to pass-through; out_sel tied 0.
// STRUCTURE
//  - Package stream_mux_pkg: ARB_RR=0, ARB_FIXED=1 constants; sel_width(n) function
//    returning max(1,clog2(n)); state enum {ST_IDLE, ST_LOCKED}.
//  - Sub-module rr_arbiter #(N, MODE): inputs req[N], ptr[SEL_W]; outputs
//    grant[N] one-hot, grant_idx[SEL_W], any. Purely combinational.
//  - Top: state/lock-index regs, pointer reg, output register, data select by grant_idx.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with in_valid=4'hF -> in_ready=0, out_valid=0,
//    out_sel=0; release -> channel 0 granted first.
//  2 RR fairness: NUM_IN=4, all valid single-beat, out_ready=1, data[i]=16'hA000+i ->
//    out_sel sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
//  3 Packet lock: ch1 sends 3 beats (last on 3rd) while ch0,ch2 valid -> out_sel=1 for
//    3 beats, in_ready[0]=in_ready[2]=0 throughout; next grant ch2.
//  4 Backpressure: out_ready=0 for 5 cycles with out_data=16'h1234 -> out_* stable,
//    in_ready=0; out_ready=1 -> 16'h1234 consumed once, next beat follows 1 cycle later.
//  5 Fixed priority: ARB_MODE=1, ch3 and ch0 valid -> ch0 served until in_valid[0]=0,
//    then ch3.
//  6 Reset mid-packet: rst_n=0 during ch2 beat 2 of 4 -> after release state IDLE,
//    pointer 0, ch0 granted if valid.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants, state encoding and sizing helper for the round-robin stream mux.
package stream_mux_pkg;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin starting at ptr, or fixed priority (index 0 highest).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int MODE  = ARB_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);
  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // Fixed priority is just a scan that always starts at 0.
      idx = (MODE == ARB_FIXED) ? k : (int'(ptr) + k) % N;
      if (!found && req[SEL_W'(idx)]) begin
        found     = 1'b1;
        grant     = N'(1) << idx;
        grant_idx = SEL_W'(idx);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with internal arbitration, packet locking and a registered output.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int WIDTH    = 16,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);
  state_e              state_q, state_d;
  logic [SEL_W-1:0]    lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;

  logic [NUM_IN-1:0]   arb_grant, grant, lock_oh;
  logic [SEL_W-1:0]    arb_idx, sel_idx;
  logic                arb_any, any_g, load, sel_last;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(.N(NUM_IN), .MODE(ARB_MODE)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    load    = !out_valid_q || out_ready;
    lock_oh = NUM_IN'(1) << lock_idx_q;
    // A locked packet owns the output; other channels wait even when valid.
    if (state_q == ST_LOCKED) begin
      grant   = in_valid & lock_oh;
      sel_idx = lock_idx_q;
      any_g   = |grant;
    end else begin
      grant   = arb_grant;
      sel_idx = arb_idx;
      any_g   = arb_any;
    end
    in_ready = (rst_n && load) ? grant : '0;

    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
        sel_last = sel_last | in_last[i];
      end
    end

    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = any_g;
      if (any_g) begin
        out_data_d = sel_data;
        out_last_d = sel_last;
        out_sel_d  = sel_idx;
        if (sel_last) begin
          state_d = ST_IDLE;
          // Pointer moves only when a packet completes.
          if (ARB_MODE == ARB_RR)
            ptr_d = (sel_idx == SEL_W'(NUM_IN-1)) ? '0 : sel_idx + 1'b1;
        end else begin
          state_d    = ST_LOCKED;
          lock_idx_d = sel_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_idx_q  <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Checks a round-robin and a fixed-priority instance, driven identically, against a queue-free reference model.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_ready;

  logic [N-1:0]   rdy [2];
  logic           ov  [2];
  logic [W-1:0]   od  [2];
  logic           ol  [2];
  logic [1:0]     os  [2];

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_IN(N), .WIDTH(W), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_sel(os[0]), .out_ready(out_ready));

  stream_mux_rr #(.NUM_IN(N), .WIDTH(W), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_sel(os[1]), .out_ready(out_ready));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m=0 round-robin, m=1 fixed priority. lock=-1 means no packet open.
  bit           m_ov  [2];
  logic [W-1:0] m_od  [2];
  bit           m_ol  [2];
  int           m_os  [2];
  int           m_lock[2];
  int           m_ptr [2];

  function automatic int pick(input int m);
    int c;
    if (m_lock[m] >= 0) return in_valid[m_lock[m]] ? m_lock[m] : -1;
    for (int k = 0; k < N; k++) begin
      c = (m == 0) ? (m_ptr[m] + k) % N : k;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_load(input int m);
    return !m_ov[m] || out_ready;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int m);
    int g;
    g = pick(m);
    if (!rst_n || !m_load(m) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0; m_lock[m] = -1; m_ptr[m] = 0;
      end else if (m_load(m)) begin
        g = pick(m);
        if (g < 0) m_ov[m] = 0;
        else begin
          m_ov[m] = 1;
          m_od[m] = in_data[g*W +: W];
          m_ol[m] = in_last[g];
          m_os[m] = g;
          if (in_last[g]) begin m_lock[m] = -1; m_ptr[m] = (g + 1) % N; end
          else m_lock[m] = g;
        end
      end
    end
  endtask

  // Called just after a negedge with inputs already set; compares, then advances one edge.
  task automatic cyc();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "rr_in_ready" : "fx_in_ready", rdy[m], exp_rdy(m));
      chk(m == 0 ? "rr_out_valid" : "fx_out_valid", ov[m], m_ov[m]);
      chk(m == 0 ? "rr_out_data" : "fx_out_data", od[m], m_od[m]);
      chk(m == 0 ? "rr_out_last" : "fx_out_last", ol[m], m_ol[m]);
      chk(m == 0 ? "rr_out_sel" : "fx_out_sel", os[m], m_os[m]);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input bit v, input logic [W-1:0] d, input bit l);
    in_valid[i] = v;
    in_data[i*W +: W] = d;
    in_last[i] = l;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(16'hA000 + i);
    @(posedge clk); model_edge(); @(negedge clk);

    // Reset held with all channels valid.
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk("rst_first_grant", rdy[0], 4'b0001);

    // Round-robin order on single-beat traffic.
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_seq_sel", os[0], k % 4);
      chk("rr_seq_data", od[0], 16'hA000 + (k % 4));
    end

    // Packet lock: pointer is now 1, ch1 sends a 3-beat packet.
    in_valid = 4'b0111; in_last = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      in_last[1] = (b == 2);
      set_ch(1, 1, W'(16'hB100 + b), b == 2);
      #1 chk("lock_ready", rdy[0], 4'b0010);
      cyc();
      chk("lock_sel", os[0], 1);
    end
    #1 chk("lock_next_ch2", rdy[0], 4'b0100);
    cyc();

    // Backpressure: hold 1234 on the output for 5 cycles.
    in_valid = '0;
    set_ch(0, 1, 16'h1234, 1);
    cyc(); cyc();
    chk("bp_loaded", od[0], 16'h1234);
    out_ready = 1'b0;
    set_ch(0, 1, 16'h5678, 1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready_low", rdy[0], 4'b0000);
      cyc();
      chk("bp_hold", od[0], 16'h1234);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", rdy[0], 4'b0001);
    cyc();
    chk("bp_next", od[0], 16'h5678);

    // Fixed priority: ch0 beats ch3 until it drops.
    in_valid = 4'b1001; in_last = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("fx_ch0_first", rdy[1], 4'b0001);
      cyc();
    end
    in_valid = 4'b1000;
    #1 chk("fx_ch3_after", rdy[1], 4'b1000);
    cyc();

    // Reset mid-packet on ch2.
    in_valid = 4'b0100; in_last = 4'b0000;
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    in_valid = 4'b0101; in_last = 4'hF;
    #1 chk("rst_mid_rr", rdy[0], 4'b0001);
    chk("rst_mid_valid", ov[0], 0);
    cyc();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
